approx_mult_err_monitor: RTL

APPROX_MULT_ERR_MONITOR -- requirements
Module: approx_mult_err_monitor

---
 rtl/approx_mult_pkg.sv | 15 +
 rtl/approx_err_dist.sv | 64 ++++++
 rtl/approx_mult_err_monitor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier error monitor:
// operand/product widths and the run-control state encoding.
package approx_mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_e;

endpackage

// File: rtl/approx_err_dist.sv
// Two-stage error-distance pipeline: stage 1 captures the operands and the
// approximate product, stage 2 holds the exact product and |x*y - z|.
module approx_err_dist
    import approx_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [OP_W-1:0]   x_i,
    input  logic [OP_W-1:0]   y_i,
    input  logic [PROD_W-1:0] z_i,
    output logic              valid_o,
    output logic [PROD_W-1:0] prod_o,
    output logic [PROD_W-1:0] ed_o
);

    logic                s1_valid_q;
    logic [OP_W-1:0]     x_q;
    logic [OP_W-1:0]     y_q;
    logic [PROD_W-1:0]   z_q;
    logic                s2_valid_q;
    logic [PROD_W-1:0]   prod_q;
    logic [PROD_W-1:0]   ed_q;

    logic [PROD_W-1:0]   prod_d;
    logic [PROD_W-1:0]   ed_d;
    logic signed [PROD_W:0] diff;

    // One extra sign bit keeps the difference exact whether z is above or below x*y.
    always_comb begin
        prod_d = x_q * y_q;
        diff   = $signed({1'b0, prod_d}) - $signed({1'b0, z_q});
        ed_d   = diff[PROD_W] ? PROD_W'(-diff) : diff[PROD_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            ed_q       <= '0;
        end else begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                x_q <= x_i;
                y_q <= y_i;
                z_q <= z_i;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                prod_q <= prod_d;
                ed_q   <= ed_d;
            end
        end
    end

    assign valid_o = s2_valid_q;
    assign prod_o  = prod_q;
    assign ed_o    = ed_q;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Measures the error of an external approximate multiplier over a run of
// samples: saturating error sum, maximum error and count of inexact products.
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int N_W   = 16,
    parameter int ACC_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    input  logic [PROD_W-1:0] z,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  err_sum,
    output logic [PROD_W-1:0] err_max,
    output logic [N_W-1:0]    err_cnt,
    output logic [N_W-1:0]    sample_cnt
);

    state_e            state_q;
    logic [N_W-1:0]    num_q;
    logic [N_W-1:0]    sample_cnt_q;
    logic [ACC_W-1:0]  err_sum_q;
    logic [PROD_W-1:0] err_max_q;
    logic [N_W-1:0]    err_cnt_q;
    logic              drain_q;
    logic              done_q;

    logic              xfer;
    logic              last_xfer;
    logic              ed_valid;
    logic [PROD_W-1:0] ed_prod;
    logic [PROD_W-1:0] ed;
    logic [ACC_W:0]    sum_ext;
    logic [ACC_W-1:0]  err_sum_d;

    assign in_ready  = (state_q == RUN) && (sample_cnt_q < num_q);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (sample_cnt_q == num_q - N_W'(1));

    approx_err_dist u_err_dist (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (xfer),
        .x_i     (x),
        .y_i     (y),
        .z_i     (z),
        .valid_o (ed_valid),
        .prod_o  (ed_prod),
        .ed_o    (ed)
    );

    // Accumulate one bit wider than the output so overflow can clamp to all-ones.
    always_comb begin
        sum_ext   = {1'b0, err_sum_q} + {{(ACC_W - PROD_W + 1){1'b0}}, ed};
        err_sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end

    // Two drain cycles cover the pipeline, so done lands with the final stage-3 update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_q        <= '0;
            sample_cnt_q <= '0;
            err_sum_q    <= '0;
            err_max_q    <= '0;
            err_cnt_q    <= '0;
            drain_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ed_valid) begin
                err_sum_q <= err_sum_d;
                if (ed > err_max_q) err_max_q <= ed;
                if (ed != '0) err_cnt_q <= err_cnt_q + N_W'(1);
            end
            case (state_q)
                IDLE, HOLD: begin
                    if (start) begin
                        num_q        <= num_samples;
                        sample_cnt_q <= '0;
                        err_sum_q    <= '0;
                        err_max_q    <= '0;
                        err_cnt_q    <= '0;
                        drain_q      <= 1'b1;
                        state_q      <= (num_samples == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        sample_cnt_q <= sample_cnt_q + N_W'(1);
                        if (last_xfer) begin
                            drain_q <= 1'b1;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        drain_q <= 1'b0;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = done_q;
    assign err_sum    = err_sum_q;
    assign err_max    = err_max_q;
    assign err_cnt    = err_cnt_q;
    assign sample_cnt = sample_cnt_q;

endmodule
